// File: rtl/ysyx_22050039_ifu.sv
// Instruction fetch unit: one outstanding request at a time, no prefetch.
// Flow per instruction: REQ (address handshake) -> WAIT (response) -> HOLD
// (instruction presented to decode until accepted). HALT and ERR are
// terminal until reset.
module ysyx_22050039_ifu #(
    parameter int                XLEN     = 64,
    parameter int                INST_LEN = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 64'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_resp_valid,
    input  logic [INST_LEN-1:0] imem_resp_data,
    input  logic                imem_resp_err,
    output logic [INST_LEN-1:0] inst,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [XLEN-1:0]     pc,
    input  logic                pc_wen,
    input  logic [XLEN-1:0]     dnpc,
    input  logic                halt,
    output logic                fetch_err,
    output logic                halted,
    output logic [XLEN-1:0]     inst_cnt
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] HOLD = 3'd3;
    localparam logic [2:0] HALT = 3'd4;
    localparam logic [2:0] ERR  = 3'd5;

    logic [2:0]          state_reg, state_next;
    logic [XLEN-1:0]     pc_reg, pc_next;
    logic [INST_LEN-1:0] inst_reg, inst_next;
    logic [XLEN-1:0]     cnt_reg, cnt_next;
    logic                err_reg, err_next;

    logic                accept;
    logic [XLEN-1:0]     target_pc;

    // The decode stage takes the held instruction this cycle.
    assign accept    = (state_reg == HOLD) && inst_ready;
    // Address of the instruction following the one being accepted.
    assign target_pc = pc_wen ? dnpc : (pc_reg + XLEN'(4));

    // Next-state and datapath update; redirect/halt inputs matter only on accept.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        inst_next  = inst_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                if (imem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    if (imem_resp_err) begin
                        state_next = ERR;
                        err_next   = 1'b1;
                    end else begin
                        inst_next  = imem_resp_data;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (accept) begin
                    cnt_next = cnt_reg + XLEN'(1);
                    pc_next  = target_pc;
                    // Halt outranks a misaligned target: the halting
                    // instruction retires cleanly without an error.
                    if (halt) begin
                        state_next = HALT;
                    end else if (target_pc[1:0] != 2'b00) begin
                        state_next = ERR;
                        err_next   = 1'b1;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            HALT: state_next = HALT;
            ERR:  state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    // State registers; reset drops any fetch in flight by returning to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            inst_reg  <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            inst_reg  <= inst_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    assign imem_req_valid = (state_reg == REQ);
    assign imem_addr      = pc_reg;
    assign inst           = inst_reg;
    assign inst_valid     = (state_reg == HOLD);
    assign pc             = pc_reg;
    assign fetch_err      = err_reg;
    assign halted         = (state_reg == HALT);
    assign inst_cnt       = cnt_reg;

endmodule
